// File: rtl/datapath_pkg.sv
// Shared datapath definitions: data/address widths and the {C,F,Z,L,N} flag layout
// used by the ALU, the register file and the board top.
package datapath_pkg;

    localparam int WIDTH      = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NFLAGS     = 5;

    localparam int FLAG_C = 4;
    localparam int FLAG_F = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    typedef logic [NFLAGS-1:0] flags_t;

    // Bits selected by sel take the new value, the rest keep the current one.
    function automatic flags_t flags_merge(flags_t cur, flags_t nxt, flags_t sel);
        return (sel & nxt) | (~sel & cur);
    endfunction

endpackage

// File: rtl/psr_reg.sv
// Processor status register: 5-bit register with per-bit masked update and
// asynchronous active-high reset.
module psr_reg
    import datapath_pkg::flags_t;
    import datapath_pkg::flags_merge;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  flags_t d,
    input  flags_t sel,
    output flags_t q
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= flags_merge(q, d, sel);
        end
    end

endmodule

// File: rtl/regfile_psr.sv
// Architectural state for the 16-bit datapath: 2R/1W register file with write
// bypass, a registered debug read port and the processor status register.
module regfile_psr
    import datapath_pkg::flags_t;
    import datapath_pkg::FLAG_C;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             wr_en,
    input  logic             wr_valid,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             psr_we,
    input  flags_t           flags_in,
    input  flags_t           flags_sel,
    output flags_t           psr,
    output logic             psr_c,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             we;

    // Gating with rst keeps the bypass from leaking write data while the array is held at zero.
    assign we = wr_en & wr_valid & ~rst;

    // NOTE: the array is reset explicitly because software relies on every register reading zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Debug copy samples the array before this edge's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end

    // NOTE: each output gets a default first so no path through the block can infer a latch.
    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
        if (we && (wr_addr == ra_addr)) begin
            ra_data = wr_data;
        end
        if (we && (wr_addr == rb_addr)) begin
            rb_data = wr_data;
        end
    end

    // psr_c comes straight from the flop so the ALU carry path never loops back through flags_in.
    psr_reg u_psr_reg (
        .clk (clk),
        .rst (rst),
        .en  (psr_we),
        .d   (flags_in),
        .sel (flags_sel),
        .q   (psr)
    );

    assign psr_c = psr[FLAG_C];

endmodule

// File: tb/tb_regfile_psr.sv
// Self-checking bench for regfile_psr: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_psr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ra_addr = '0, rb_addr = '0, wr_addr = '0, dbg_addr = '0;
    logic [15:0] ra_data, rb_data, dbg_data;
    logic        wr_en = 1'b0, wr_valid = 1'b0, psr_we = 1'b0;
    logic [15:0] wr_data = '0;
    logic [4:0]  flags_in = '0, flags_sel = '0, psr;
    logic        psr_c;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state
    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;
    logic [15:0] m_dbg;

    always #5 clk = ~clk;

    regfile_psr dut (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .wr_en    (wr_en),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .psr_we   (psr_we),
        .flags_in (flags_in),
        .flags_sel(flags_sel),
        .psr      (psr),
        .psr_c    (psr_c),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: state as the architecture describes it, updated once per edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
            m_psr = 5'b0;
            m_dbg = 16'h0;
        end else begin
            m_dbg = m_regs[dbg_addr];
            if (wr_en && wr_valid) m_regs[wr_addr] = wr_data;
            if (psr_we)
                for (int i = 0; i < 5; i++)
                    if (flags_sel[i]) m_psr[i] = flags_in[i];
        end
    end

    function automatic logic [15:0] model_read(input logic [3:0] a);
        if (!rst && wr_en && wr_valid && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    // Every-cycle comparison, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ra_data", 32'(ra_data), 32'(model_read(ra_addr)));
            check("rb_data", 32'(rb_data), 32'(model_read(rb_addr)));
            check("psr", 32'(psr), 32'(m_psr));
            check("psr_c", 32'(psr_c), 32'(m_psr[4]));
            check("dbg_data", 32'(dbg_data), 32'(m_dbg));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_valid = 1'b0; psr_we = 1'b0;
        flags_in = '0; flags_sel = '0;
    endtask

    logic [16:0] alu_sum;

    initial begin
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("reset_ra", 32'(ra_data), 32'h0);
        check("reset_psr", 32'(psr), 32'h0);
        check("reset_dbg", 32'(dbg_data), 32'h0);

        // Gated write: R2 = 7, then an unqualified write must be dropped
        wr_en = 1; wr_valid = 1; wr_addr = 2; wr_data = 16'h0007;
        step();
        wr_valid = 0; wr_data = 16'hFFFF; ra_addr = 2;
        #1 check("gated_no_bypass", 32'(ra_data), 32'h0007);
        step();
        idle_inputs();
        #1 check("gated_r2_kept", 32'(ra_data), 32'h0007);

        // Write/read with bypass on both ports
        wr_en = 1; wr_valid = 1; wr_addr = 5; wr_data = 16'h00A0;
        ra_addr = 5; rb_addr = 5;
        #1 check("bypass_a", 32'(ra_data), 32'h00A0);
        check("bypass_b", 32'(rb_data), 32'h00A0);
        step();
        idle_inputs();
        #1 check("stored_a", 32'(ra_data), 32'h00A0);
        check("stored_b", 32'(rb_data), 32'h00A0);

        // Masked PSR update from zero
        psr_we = 1; flags_in = 5'b11111; flags_sel = 5'b10100;
        #1 check("psr_no_bypass", 32'(psr), 32'h0);
        step();
        flags_sel = 5'b00000;
        #1 check("psr_masked", 32'(psr), 32'b10100);
        check("psr_c_set", 32'(psr_c), 32'h1);
        step();
        idle_inputs();
        #1 check("psr_sel_zero", 32'(psr), 32'b10100);

        // ALU loop: R1 = FFF8, ADD 16, write back with all flags
        wr_en = 1; wr_valid = 1; wr_addr = 1; wr_data = 16'hFFF8;
        psr_we = 1; flags_in = 5'b00000; flags_sel = 5'b11111;
        step();
        ra_addr = 1;
        alu_sum = {1'b0, 16'hFFF8} + 17'd16;
        wr_data = alu_sum[15:0];
        flags_in = {alu_sum[16], 4'b0000};
        #1 check("loop_c_stable", 32'(psr_c), 32'h0);
        step();
        idle_inputs();
        #1 check("loop_r1", 32'(ra_data), 32'h0008);
        check("loop_c", 32'(psr_c), 32'h1);

        // Debug port shows old value on the write edge, new value one cycle later
        dbg_addr = 5;
        step();
        wr_en = 1; wr_valid = 1; wr_addr = 5; wr_data = 16'h0042;
        #1 check("dbg_before", 32'(dbg_data), 32'h00A0);
        step();
        idle_inputs();
        #1 check("dbg_write_edge", 32'(dbg_data), 32'h00A0);
        step();
        #1 check("dbg_after", 32'(dbg_data), 32'h0042);

        // Asynchronous reset between edges
        wr_en = 1; wr_valid = 1; wr_addr = 3; wr_data = 16'h1234;
        psr_we = 1; flags_in = 5'b11111; flags_sel = 5'b11111;
        step();
        idle_inputs();
        ra_addr = 3;
        #1 check("preload_r3", 32'(ra_data), 32'h1234);
        check("preload_psr", 32'(psr), 32'b11111);
        rst = 1'b1;
        #1 check("async_rst_ra", 32'(ra_data), 32'h0);
        check("async_rst_psr", 32'(psr), 32'h0);
        check("async_rst_psr_c", 32'(psr_c), 32'h0);
        step();
        rst = 1'b0;

        // Randomized traffic, with occasional mid-cycle reset pulses
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            rst       = ($urandom_range(0, 49) == 0);
            ra_addr   = 4'($urandom);
            rb_addr   = ($urandom_range(0, 3) == 0) ? ra_addr : 4'($urandom);
            wr_addr   = ($urandom_range(0, 2) == 0) ? ra_addr : 4'($urandom);
            dbg_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom);
            wr_en     = 1'($urandom);
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_data   = 16'($urandom);
            psr_we    = 1'($urandom);
            flags_in  = 5'($urandom);
            flags_sel = 5'($urandom);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
